// File: rtl/half_link_channel_pkg.sv
// -----------------------------------------------------------------------------
// half_link_pkg
// Shared definitions for the inter-half link between the left and right
// decoder halves.
//   finalFifoWidth(x, z) : width of one final-arbitration FIFO message for a
//                          decoder of X distance x and Z distance z
//                          (25 for the default 5 x 4 decoder).
//   LINK_MAX_WIDTH       : widest message a link pipe stage can carry.
//   link_msg_t           : one pipe stage, {valid, data}. Narrower messages
//                          are zero-extended into the data field.
// -----------------------------------------------------------------------------
package half_link_pkg;

  localparam int LINK_MAX_WIDTH = 64;

  // Message width: three coordinates of clog2(max(X,Z)) bits for each of two
  // endpoints plus two flag bits, followed by a cluster index that has to
  // address max(X,Z)*Z positions.
  function automatic int finalFifoWidth(input int x, input int z);
    int maxDist;
    int coordBits;
    maxDist   = (x > z) ? x : z;
    coordBits = $clog2(maxDist);
    return (2 * 3 * coordBits + 2) + $clog2(maxDist * z);
  endfunction

  typedef struct packed {
    logic                      valid;
    logic [LINK_MAX_WIDTH-1:0] data;
  } link_msg_t;

endpackage

// File: rtl/half_link_channel_if.sv
// -----------------------------------------------------------------------------
// half_link_channel_if
// Valid/ready message bus between one decoder half's final FIFO and the link.
//   data  : message payload (WIDTH bits)
//   valid : producer has a message on data
//   ready : consumer takes the message when valid & ready
// Modports:
//   master : the producer side (drives data/valid, observes ready)
//   slave  : the consumer side (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface half_link_channel_if
  import half_link_pkg::*;
#(
  parameter int WIDTH = finalFifoWidth(5, 4)
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/half_link_channel_lane.sv
// -----------------------------------------------------------------------------
// half_link_lane
// One direction of the inter-half link: credit counter on the sending side,
// LATENCY-stage data pipe, DEPTH-entry first-word-fall-through receive FIFO,
// and a LATENCY-stage pipe carrying one credit back per FIFO pop.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   sndData_i/sndValid_i  : message offered by the sending half
//   sndReady_o            : a credit is available (from the credit register)
//   rcvData_o/rcvValid_o  : FIFO head presented to the receiving half
//   rcvReady_i            : receiving half pops the head
//   accept_o              : a message was taken from the sender this cycle
//   busy_o                : credits outstanding, i.e. something is in transit
// -----------------------------------------------------------------------------
module half_link_lane
  import half_link_pkg::*;
#(
  parameter int WIDTH   = 25,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sndData_i,
  input  logic             sndValid_i,
  output logic             sndReady_o,
  output logic [WIDTH-1:0] rcvData_o,
  output logic             rcvValid_o,
  input  logic             rcvReady_i,
  output logic             accept_o,
  output logic             busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [CW-1:0]      creditCnt_q, creditCnt_d;
  link_msg_t          dataPipe_q [LATENCY];
  logic [LATENCY-1:0] creditPipe_q;
  logic [WIDTH-1:0]   fifoMem_q [DEPTH];
  logic [PW-1:0]      rdPtr_q, rdPtr_d;
  logic [PW-1:0]      wrPtr_q, wrPtr_d;
  logic [CW-1:0]      fifoCnt_q, fifoCnt_d;
  logic               accept;
  logic               pop;
  logic               fifoWrite;
  logic               creditRet;
  link_msg_t          pipeIn;

  assign sndReady_o = (creditCnt_q != '0);
  assign accept     = sndValid_i & sndReady_o;
  assign accept_o   = accept;
  assign busy_o     = (creditCnt_q != DEPTH_C);
  assign creditRet  = creditPipe_q[LATENCY-1];
  assign fifoWrite  = dataPipe_q[LATENCY-1].valid;
  assign rcvValid_o = (fifoCnt_q != '0);
  assign rcvData_o  = fifoMem_q[rdPtr_q];
  assign pop        = rcvValid_o & rcvReady_i;

  // Only the low WIDTH bits of the last stage reach the FIFO; the upper pad
  // bits are always zero and are folded here so they count as consumed.
  if (WIDTH < LINK_MAX_WIDTH) begin : gUnusedPad
    logic unusedPadBits;
    assign unusedPadBits = ^dataPipe_q[LATENCY-1].data[LINK_MAX_WIDTH-1:WIDTH];
  end

  // Message entering the data pipe: valid only when the sender was accepted.
  always_comb begin
    pipeIn       = '0;
    pipeIn.valid = accept;
    pipeIn.data  = LINK_MAX_WIDTH'(sndData_i);
  end

  // Credit counter: an accept spends a credit, a returning token restores
  // one, and both in the same cycle cancel out.
  always_comb begin
    creditCnt_d = creditCnt_q;
    if (accept && !creditRet) begin
      creditCnt_d = creditCnt_q - CNT_ONE;
    end else if (!accept && creditRet) begin
      creditCnt_d = creditCnt_q + CNT_ONE;
    end
  end

  // Receive FIFO bookkeeping. Pointers wrap at DEPTH so non-power-of-two
  // depths work; write and pop may coincide even when full or empty.
  always_comb begin
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    fifoCnt_d = fifoCnt_q;
    if (pop) begin
      rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PTR_ONE;
    end
    if (fifoWrite) begin
      wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PTR_ONE;
    end
    if (fifoWrite && !pop) begin
      fifoCnt_d = fifoCnt_q + CNT_ONE;
    end else if (!fifoWrite && pop) begin
      fifoCnt_d = fifoCnt_q - CNT_ONE;
    end
  end

  // State registers. Reset drops everything in flight and refills the
  // credits, which is consistent because the FIFO and both pipes are emptied.
  always_ff @(posedge clk) begin
    if (reset) begin
      creditCnt_q  <= DEPTH_C;
      creditPipe_q <= '0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      fifoCnt_q    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dataPipe_q[i] <= '0;
      end
    end else begin
      creditCnt_q     <= creditCnt_d;
      rdPtr_q         <= rdPtr_d;
      wrPtr_q         <= wrPtr_d;
      fifoCnt_q       <= fifoCnt_d;
      dataPipe_q[0]   <= pipeIn;
      creditPipe_q[0] <= pop;
      for (int i = 1; i < LATENCY; i++) begin
        dataPipe_q[i]   <= dataPipe_q[i-1];
        creditPipe_q[i] <= creditPipe_q[i-1];
      end
    end
  end

  // FIFO storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clk) begin
    if (fifoWrite) begin
      fifoMem_q[wrPtr_q] <= dataPipe_q[LATENCY-1].data[WIDTH-1:0];
    end
  end

  // The credit loop guarantees the FIFO never overflows and the credit
  // counter never climbs past DEPTH; either would mean a broken token path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(creditRet && !accept && (creditCnt_q == DEPTH_C)));
      assert (!(fifoWrite && !pop && (fifoCnt_q == DEPTH_C)));
    end
  end

endmodule

// File: rtl/half_link_channel.sv
// -----------------------------------------------------------------------------
// half_link_channel
// Bidirectional link between the left and right decoder halves. Two
// half_link_lane instances carry final-FIFO messages L2R and R2L with credit
// flow control; each half's status flags reach the other half LATENCY cycles
// later, and any traffic still inside the link is reported as flying.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   left_out / right_out (slave)   : messages leaving each half's final FIFO
//   left_in  / right_in  (master)  : messages delivered into each half
//   {left,right}_has_message_flying, {left,right}_has_odd_clusters : raw flags
//   {left,right}_has_*_otherside   : the opposite half's flags, delayed
//   l2r_msg_count, r2l_msg_count   : saturating accept counters, present only
//                                    when HALF_LINK_STATS_EN is defined
// -----------------------------------------------------------------------------
module half_link_channel
  import half_link_pkg::*;
#(
  parameter int CODE_DISTANCE_X = 5,
  parameter int CODE_DISTANCE_Z = 4,
  parameter int DEPTH           = 4,
  parameter int LATENCY         = 3
) (
  input  logic clk,
  input  logic reset,
  half_link_channel_if.slave  left_out,
  half_link_channel_if.master left_in,
  half_link_channel_if.slave  right_out,
  half_link_channel_if.master right_in,
  input  logic left_has_message_flying,
  input  logic left_has_odd_clusters,
  input  logic right_has_message_flying,
  input  logic right_has_odd_clusters,
  output logic left_has_message_flying_otherside,
  output logic left_has_odd_clusters_otherside,
  output logic right_has_message_flying_otherside,
  output logic right_has_odd_clusters_otherside
`ifdef HALF_LINK_STATS_EN
  ,
  output logic [31:0] l2r_msg_count,
  output logic [31:0] r2l_msg_count
`endif
);

  localparam int FINAL_FIFO_WIDTH = finalFifoWidth(CODE_DISTANCE_X, CODE_DISTANCE_Z);

  logic       l2rBusy, r2lBusy;
  logic       l2rAccept, r2lAccept;
  logic [3:0] rawFlags;
  logic [3:0] flagPipe_q [LATENCY];
  logic [3:0] flagsDelayed;

  half_link_lane #(
    .WIDTH  (FINAL_FIFO_WIDTH),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) u_l2r (
    .clk       (clk),
    .reset     (reset),
    .sndData_i (left_out.data),
    .sndValid_i(left_out.valid),
    .sndReady_o(left_out.ready),
    .rcvData_o (right_in.data),
    .rcvValid_o(right_in.valid),
    .rcvReady_i(right_in.ready),
    .accept_o  (l2rAccept),
    .busy_o    (l2rBusy)
  );

  half_link_lane #(
    .WIDTH  (FINAL_FIFO_WIDTH),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) u_r2l (
    .clk       (clk),
    .reset     (reset),
    .sndData_i (right_out.data),
    .sndValid_i(right_out.valid),
    .sndReady_o(right_out.ready),
    .rcvData_o (left_in.data),
    .rcvValid_o(left_in.valid),
    .rcvReady_i(left_in.ready),
    .accept_o  (r2lAccept),
    .busy_o    (r2lBusy)
  );

  // Bits 3:2 travel to the left half, bits 1:0 to the right half.
  assign rawFlags = {right_has_message_flying, right_has_odd_clusters,
                     left_has_message_flying,  left_has_odd_clusters};

  // Flag shift registers give the flags the same latency as the data pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        flagPipe_q[i] <= '0;
      end
    end else begin
      flagPipe_q[0] <= rawFlags;
      for (int i = 1; i < LATENCY; i++) begin
        flagPipe_q[i] <= flagPipe_q[i-1];
      end
    end
  end

  assign flagsDelayed = flagPipe_q[LATENCY-1];

  // Traffic inside the link in either direction keeps both halves from
  // terminating; the busy terms come straight from the credit registers.
  assign left_has_message_flying_otherside  = flagsDelayed[3] | l2rBusy | r2lBusy;
  assign left_has_odd_clusters_otherside    = flagsDelayed[2];
  assign right_has_message_flying_otherside = flagsDelayed[1] | l2rBusy | r2lBusy;
  assign right_has_odd_clusters_otherside   = flagsDelayed[0];

`ifdef HALF_LINK_STATS_EN
  logic [31:0] l2rCount_q, r2lCount_q;

  // Accept counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      l2rCount_q <= '0;
      r2lCount_q <= '0;
    end else begin
      if (l2rAccept && (l2rCount_q != '1)) begin
        l2rCount_q <= l2rCount_q + 32'd1;
      end
      if (r2lAccept && (r2lCount_q != '1)) begin
        r2lCount_q <= r2lCount_q + 32'd1;
      end
    end
  end

  assign l2r_msg_count = l2rCount_q;
  assign r2l_msg_count = r2lCount_q;
`else
  logic unusedAccepts;
  assign unusedAccepts = l2rAccept ^ r2lAccept;
`endif

endmodule
